// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Optional parity bit compiled in when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // Reject illegal configurations at elaboration time
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    state_t               state_q, state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Next-state and next-line logic; all bit boundaries move on tick only
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d    = in_data;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d      = (^in_data) ^ (PARITY_ODD != 0);
`endif
                    state_d    = SYNC;
                end
            end
            SYNC: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = CW'(1);
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q < CW'(DATA_BITS)) begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: one default instance and one
// with two stop bits and odd parity sense; tick pulses every 4 clk.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    int         tcnt = 0;
    logic [7:0] d1, d2;
    logic       v1, v2;
    logic       rdy1, rdy2, tx1, tx2, busy1, busy2, done1, done2;
    int         dc1 = 0, dc2 = 0;
    int         tests = 0, fails = 0;

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .in_data(d1),
        .in_valid(v1), .in_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1)
    );

    uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .in_data(d2),
        .in_valid(v2), .in_ready(rdy2), .tx(tx2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcnt <= (tcnt == 3) ? 0 : tcnt + 1;
    assign tick = (tcnt == 3);

    always @(negedge clk) begin
        if (done1) dc1 <= dc1 + 1;
        if (done2) dc2 <= dc2 + 1;
    end

    // Expected frame, bit k = line level during tick period k
    function automatic logic [15:0] mk(input logic [7:0] d, input logic pb);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (P == 1) f[9] = pb;
        return f;
    endfunction

    task automatic wait_tick;
        int g;
        g = 0;
        while (!tick && g < 16) begin
            @(negedge clk);
            g++;
        end
        if (!tick) begin
            tests++; fails++;
            $display("FAIL tick_timeout got no tick within %0d clk", g);
        end
        @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] d);
        int g;
        g = 0;
        if (sel) begin d2 = d; v2 = 1'b1; end
        else begin d1 = d; v1 = 1'b1; end
        while (!(sel ? rdy2 : rdy1) && g < 64) begin
            @(negedge clk);
            g++;
        end
        if (!(sel ? rdy2 : rdy1)) begin
            tests++; fails++;
            $display("FAIL send_timeout in_ready got 0 exp 1");
        end
        @(negedge clk);
        if (sel) v2 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic capture(input bit sel, input int n, output logic [15:0] f,
                           output time t0, output bit busy_all);
        f = '1;
        t0 = 0;
        busy_all = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_tick;
            f[k] = sel ? tx2 : tx1;
            if (k == 0) t0 = $time;
            if (!(sel ? busy2 : busy1)) busy_all = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0;
        repeat (3) @(negedge clk);
        tests++; if (tx1 !== 1'b1) begin fails++; $display("FAIL rst_tx got %b exp 1", tx1); end
        tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy1); end
        tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", done1); end
        tests++; if (rdy1 !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", rdy1); end
        tests++; if (tx2 !== 1'b1) begin fails++; $display("FAIL rst_tx2 got %b exp 1", tx2); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
            fails++; $display("FAIL post_rst_idle got tx=%b busy=%b exp tx=1 busy=0", tx1, busy1);
        end
    endtask

    task automatic test_basic;
        logic [15:0] f, e;
        time t0;
        bit ba;
        int c0;
        c0 = dc1;
        send(1'b0, 8'hA5);
        capture(1'b0, 10 + P, f, t0, ba);
        e = mk(8'hA5, 1'b0);
        tests++; if (f !== e) begin fails++; $display("FAIL basic_frame got %h exp %h", f, e); end
        tests++; if (!ba) begin fails++; $display("FAIL basic_busy got low mid-frame exp high"); end
        wait_tick;
        tests++; if (done1 !== 1'b1) begin fails++; $display("FAIL basic_done got %b exp 1", done1); end
        tests++; if (rdy1 !== 1'b1 || tx1 !== 1'b1) begin
            fails++; $display("FAIL basic_end got rdy=%b tx=%b exp 1 1", rdy1, tx1);
        end
        @(negedge clk);
        tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b exp 0", done1); end
        tests++; if (dc1 - c0 != 1) begin fails++; $display("FAIL basic_done_cnt got %0d exp 1", dc1 - c0); end
    endtask

    task automatic test_stop2;
        logic [15:0] f, e;
        time t0;
        bit ba;
        send(1'b1, 8'h00);
        capture(1'b1, 11 + P, f, t0, ba);
        e = mk(8'h00, 1'b1);
        tests++; if (f !== e) begin fails++; $display("FAIL stop2_frame got %h exp %h", f, e); end
        tests++; if (done2 !== 1'b0) begin fails++; $display("FAIL stop2_early_done got %b exp 0", done2); end
        wait_tick;
        tests++; if (done2 !== 1'b1 || tx2 !== 1'b1) begin
            fails++; $display("FAIL stop2_done got done=%b tx=%b exp 1 1", done2, tx2);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [15:0] f, e;
        time t0, td;
        bit ba, bad;
        int c0, g, gap;
        c0 = dc1;
        g = 0;
        d1 = 8'h55; v1 = 1'b1;
        while (!rdy1 && g < 64) begin @(negedge clk); g++; end
        @(negedge clk);
        d1 = 8'h0F;
        capture(1'b0, 10 + P, f, t0, ba);
        e = mk(8'h55, 1'b0);
        tests++; if (f !== e) begin fails++; $display("FAIL b2b_frame1 got %h exp %h", f, e); end
        wait_tick;
        td = $time;
        tests++; if (done1 !== 1'b1) begin fails++; $display("FAIL b2b_done1 got %b exp 1", done1); end
        @(negedge clk);
        v1 = 1'b0;
        tests++; if (rdy1 !== 1'b0) begin fails++; $display("FAIL b2b_accept2 got ready=%b exp 0", rdy1); end
        capture(1'b0, 10 + P, f, t0, ba);
        e = mk(8'h0F, 1'b0);
        tests++; if (f !== e) begin fails++; $display("FAIL b2b_frame2 got %h exp %h", f, e); end
        gap = int'((t0 - td) / 10);
        tests++; if (gap < 1 || gap > 8) begin
            fails++; $display("FAIL b2b_gap got %0d clk exp 1..8", gap);
        end
        wait_tick;
        tests++; if (done1 !== 1'b1) begin fails++; $display("FAIL b2b_done2 got %b exp 1", done1); end
        bad = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) bad = 1'b1;
        end
        tests++; if (bad) begin fails++; $display("FAIL b2b_no_third got activity exp idle"); end
        tests++; if (dc1 - c0 != 2) begin fails++; $display("FAIL b2b_done_cnt got %0d exp 2", dc1 - c0); end
    endtask

    task automatic test_tick_coincident;
        logic [15:0] f, e;
        time t0;
        bit ba;
        int g, n;
        g = 0;
        while (!tick && g < 8) begin @(negedge clk); g++; end
        tests++; if (rdy1 !== 1'b1 || tick !== 1'b1) begin
            fails++; $display("FAIL coin_setup got ready=%b tick=%b exp 1 1", rdy1, tick);
        end
        d1 = 8'h96; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        tests++; if (tx1 !== 1'b1 || busy1 !== 1'b1) begin
            fails++; $display("FAIL coin_ignored got tx=%b busy=%b exp 1 1", tx1, busy1);
        end
        n = 0;
        while (tx1 === 1'b1 && n < 12) begin @(negedge clk); n++; end
        tests++; if (n != 4) begin fails++; $display("FAIL coin_latency got %0d clk exp 4", n); end
        capture(1'b0, 9 + P, f, t0, ba);
        e = mk(8'h96, 1'b0);
        e = {1'b1, e[15:1]};
        tests++; if (f !== e) begin fails++; $display("FAIL coin_frame got %h exp %h", f, e); end
        wait_tick;
        tests++; if (done1 !== 1'b1) begin fails++; $display("FAIL coin_done got %b exp 1", done1); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [15:0] f, e;
        time t0;
        bit ba;
        send(1'b0, 8'h00);
        capture(1'b0, 5, f, t0, ba);
        tests++; if (tx1 !== 1'b0) begin fails++; $display("FAIL mid_bit3 got %b exp 0", tx1); end
        rst_n = 1'b0;
        #1;
        tests++; if (tx1 !== 1'b1) begin fails++; $display("FAIL mid_rst_tx got %b exp 1", tx1); end
        tests++; if (busy1 !== 1'b0 || rdy1 !== 1'b1) begin
            fails++; $display("FAIL mid_rst_state got busy=%b ready=%b exp 0 1", busy1, rdy1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, 8'h3C);
        capture(1'b0, 10 + P, f, t0, ba);
        e = mk(8'h3C, 1'b0);
        tests++; if (f !== e) begin fails++; $display("FAIL mid_after_frame got %h exp %h", f, e); end
        wait_tick;
        tests++; if (done1 !== 1'b1) begin fails++; $display("FAIL mid_after_done got %b exp 1", done1); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stop2;
        test_back_to_back;
        test_tick_coincident;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter that consumes the 1x baud-rate tick from the baud generator and serialises parallel bytes onto the tx line.
- Frame format: start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- Upstream side uses a valid/ready byte handshake; downstream side is the pad/line driver.
- All tx line transitions align to baud ticks, so every bit lasts exactly one tick period.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only when UART_TX_PARITY_EN is defined.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset, asynchronous, active-low.
tick  input  1  one-clk pulse per bit period, from the baud generator.
in_data  input  DATA_BITS  byte to send; sampled on accept.
in_valid  input  1  upstream has a byte.
in_ready  output  1  block can accept; equals (state == IDLE).
tx  output  1  serial line; idle high; registered.
busy  output  1  high in any state other than IDLE.
done  output  1  one-clk pulse when the final stop bit completes.

Behaviour:
- Reset state: state = IDLE, tx = 1, busy = 0, done = 0, in_ready = 1, shift register = 0, counters = 0. Asserting rst_n low mid-frame aborts the frame immediately. The next frame after release starts fresh; there is no partial-frame resume.
- Accept: the byte is accepted on a clk edge where in_valid && in_ready. in_data is latched into the shift register. state moves to SYNC. in_ready falls the next cycle.
- A tick in the same cycle as accept is ignored; SYNC waits for a later tick.
- States and transitions (all transitions happen only on a clk edge with tick = 1, except the IDLE -> SYNC accept):
  - SYNC: on tick, tx <= 0, go to START.
  - START: on tick, tx <= shreg[0], shift right, bit_cnt <= 1, go to DATA.
  - DATA: on tick, while bit_cnt < DATA_BITS: tx <= next bit, bit_cnt++.
  - DATA exit: after DATA_BITS bits have been driven, the next tick goes to PARITY (feature on) or STOP (feature off).
  - PARITY: tx drives the parity bit for one tick period, then goes to STOP.
  - STOP: tx <= 1 for STOP_BITS tick periods, counted by stop_cnt.
  - STOP exit: on the tick that ends the last stop bit, state <= IDLE and done <= 1 for exactly one clk. tx stays 1.
- Frame length: exactly 1 + DATA_BITS + P + STOP_BITS tick periods, where P = 1 with parity, 0 without.
- Accept-to-line latency: the start bit begins on the first tick strictly after the accept cycle.
- Back-to-back: a byte presented while done pulses is accepted on the following cycle, since in_ready is high in IDLE. Its start bit waits for the next tick. Between frames the line gives at least 0 and at most 1 tick period of extra idle high.
- in_data changes after accept do not affect the frame in flight.
- No FIFO; upstream must hold in_valid until in_ready.
- Parity is computed over the latched data at accept time. even = XOR of the bits; odd = ~XOR.
- tick is assumed to be a single-cycle pulse. Ticks in consecutive clocks are each honoured as separate bit boundaries.
- Width rules:
  - bit_cnt is $clog2(DATA_BITS+1) bits wide.
  - stop_cnt is 1 bit wide.
  - No counter wraps within a legal frame.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: the PARITY state is compiled in and one parity bit is inserted after the data bits, with sense set by PARITY_ODD.
- Undefined: the PARITY state and its logic are absent, PARITY_ODD is ignored, and DATA exits directly to STOP.

Test Plan:
- Basic frame, no parity, DATA_BITS=8, STOP_BITS=1, bench tick every 4 clk, send 0xA5 -> tx sequence per tick: 0, 1,0,1,0,0,1,0,1, 1. done pulses once. busy spans 10 tick periods after SYNC.
- Parity, macro defined, send 0xA5 (four 1s) -> parity bit is 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1. Frame is 11 tick periods.
- STOP_BITS=2, send 0x00 -> tx low for 9 tick periods, then high for 2 tick periods. done is asserted at the end of the second stop bit.
- Back-to-back 0x55 then 0x0F with in_valid held high -> second start bit occurs within 1 tick period of the first frame's done. No data corruption; each byte is accepted exactly once.
- Accept coincident with tick -> that tick is ignored. The start bit falls on the next tick, 4 clk later.
- Assert rst_n low during data bit 3 -> tx = 1, busy = 0, in_ready = 1 immediately. After release, 0x3C is sent cleanly.
